// File: rtl/imm_encoder.sv
// imm_encoder: packs an I-type request into one instruction word, or into a
// lui/ori/R-type triple through the scratch register when the immediate is too wide.
`default_nettype none

module imm_encoder #(
  parameter logic [4:0] AT_REG = 5'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        out_err
);

  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SINGLE = 3'd1,
    S_LUI    = 3'd2,
    S_ORI    = 3'd3,
    S_RTYPE  = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        last_q, last_d;
  logic [4:0]  rs_q, rs_d;
  logic [4:0]  rt_q, rt_d;
  logic [15:0] imm_lo_q, imm_lo_d;
  logic [5:0]  funct_q, funct_d;

  logic       signed_fit, unsigned_fit;
  logic       op_known, op_fit, op_expandable, at_clash;
  logic [5:0] op_funct;

  always_comb begin
    signed_fit    = (&in_imm[31:15]) || (~|in_imm[31:15]);
    unsigned_fit  = ~|in_imm[31:16];
    op_known      = 1'b1;
    op_fit        = signed_fit;
    op_expandable = 1'b0;
    op_funct      = 6'b000000;
    unique case (in_op)
      OP_ADDI:  begin op_expandable = 1'b1; op_funct = FN_ADD;  end
      OP_ADDIU: begin op_expandable = 1'b1; op_funct = FN_ADDU; end
      OP_SLTI:  begin op_expandable = 1'b1; op_funct = FN_SLT;  end
      OP_ANDI:  begin op_fit = unsigned_fit; op_expandable = 1'b1; op_funct = FN_AND; end
      OP_ORI:   begin op_fit = unsigned_fit; op_expandable = 1'b1; op_funct = FN_OR;  end
      OP_LW, OP_SW, OP_BEQ, OP_BNE: ;
      default:  op_known = 1'b0;
    endcase
    at_clash = (in_rs == AT_REG) || (in_rt == AT_REG);
  end

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    last_d   = last_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    imm_lo_d = imm_lo_q;
    funct_d  = funct_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          rs_d     = in_rs;
          rt_d     = in_rt;
          imm_lo_d = in_imm[15:0];
          funct_d  = op_funct;
          if (op_known && op_fit) begin
            state_d = S_SINGLE;
            instr_d = {in_op, in_rs, in_rt, in_imm[15:0]};
            last_d  = 1'b1;
          end else if (op_known && op_expandable && !at_clash) begin
            state_d = S_LUI;
            instr_d = {OP_LUI, 5'b00000, AT_REG, in_imm[31:16]};
            last_d  = 1'b0;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_LUI: begin
        if (out_ready) begin
          state_d = S_ORI;
          instr_d = {OP_ORI, AT_REG, AT_REG, imm_lo_q};
        end
      end
      S_ORI: begin
        if (out_ready) begin
          state_d = S_RTYPE;
          instr_d = {6'b000000, rs_q, AT_REG, rt_q, 5'b00000, funct_q};
          last_d  = 1'b1;
        end
      end
      S_SINGLE, S_RTYPE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          instr_d = 32'h0;
          last_d  = 1'b0;
        end
      end
      S_ERR:   state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        instr_d = 32'h0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      instr_q  <= 32'h0;
      last_q   <= 1'b0;
      rs_q     <= 5'h0;
      rt_q     <= 5'h0;
      imm_lo_q <= 16'h0;
      funct_q  <= 6'h0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      last_q   <= last_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      imm_lo_q <= imm_lo_d;
      funct_q  <= funct_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_err   = (state_q == S_ERR);
  assign out_valid = (state_q == S_SINGLE) || (state_q == S_LUI) ||
                     (state_q == S_ORI)    || (state_q == S_RTYPE);
  assign out_instr = instr_q;
  assign out_last  = last_q;

endmodule

`default_nettype wire

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed checks of imm_encoder against hand-encoded words.
`default_nettype none

module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;
  logic        out_err;

  int tests = 0;
  int fails = 0;

  imm_encoder #(.AT_REG(5'd1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_last  (out_last),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for exactly one edge, then scramble the fields.
  task automatic send(input logic [5:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [31:0] imm);
    in_valid = 1'b1;
    in_op    = op;
    in_rs    = rs;
    in_rt    = rt;
    in_imm   = imm;
    tick();
    in_valid = 1'b0;
    in_op    = 6'($urandom);
    in_rs    = 5'($urandom);
    in_rt    = 5'($urandom);
    in_imm   = $urandom;
  endtask

  task automatic word(input string tag, input logic [31:0] exp, input logic last);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_instr"}, out_instr, exp);
    chk({tag, "_last"}, {31'b0, out_last}, {31'b0, last});
    chk({tag, "_inrdy"}, {31'b0, in_ready}, 32'd0);
  endtask

  task automatic idle(input string tag);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_inrdy"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic err(input string tag);
    chk({tag, "_err"}, {31'b0, out_err}, 32'd1);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_inrdy"}, {31'b0, in_ready}, 32'd0);
    tick();
    chk({tag, "_errpulse"}, {31'b0, out_err}, 32'd0);
    idle(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 6'h0;
    in_rs     = 5'h0;
    in_rt     = 5'h0;
    in_imm    = 32'h0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_inrdy", {31'b0, in_ready}, 32'd1);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_last", {31'b0, out_last}, 32'd0);
    chk("rst_err", {31'b0, out_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // addiu $3,$2,-4 fits in 16 bits
    send(6'b001001, 5'd2, 5'd3, 32'hFFFF_FFFC);
    word("addiu", 32'h2443_FFFC, 1'b1);
    tick();
    idle("addiu_done");

    // addi $5,$4,0x12345 expands
    send(6'b001000, 5'd4, 5'd5, 32'h0001_2345);
    word("addi_w1", 32'h3C01_0001, 1'b0);
    tick();
    word("addi_w2", 32'h3421_2345, 1'b0);
    tick();
    word("addi_w3", 32'h0081_2820, 1'b1);
    tick();
    idle("addi_done");

    // signed boundary: 0xFFFF8000 fits for addi
    send(6'b001000, 5'd7, 5'd8, 32'hFFFF_8000);
    word("addi_neg", 32'h20E8_8000, 1'b1);
    tick();

    // unsigned boundary: ori accepts 0x8000, andi with 0x10000 expands
    send(6'b001101, 5'd0, 5'd6, 32'h0000_8000);
    word("ori_fit", 32'h3406_8000, 1'b1);
    tick();
    idle("ori_done");
    send(6'b001100, 5'd2, 5'd3, 32'h0001_0000);
    word("andi_w1", 32'h3C01_0001, 1'b0);
    tick();
    word("andi_w2", 32'h3421_0000, 1'b0);
    tick();
    word("andi_w3", 32'h0041_1824, 1'b1);
    tick();
    idle("andi_done");

    // rejections
    send(6'b100011, 5'd2, 5'd3, 32'h0000_8000);
    err("lw_wide");
    send(6'b001000, 5'd2, 5'd1, 32'h0001_0000);
    err("addi_at");
    send(6'b111111, 5'd2, 5'd3, 32'h0000_0000);
    err("bad_op");

    // backpressure on the ori word
    send(6'b001000, 5'd4, 5'd5, 32'h0001_2345);
    word("bp_w1", 32'h3C01_0001, 1'b0);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      word("bp_hold", 32'h3421_2345, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    word("bp_w3", 32'h0081_2820, 1'b1);
    tick();
    idle("bp_done");

    // asynchronous reset while the ori word is pending
    send(6'b001000, 5'd4, 5'd5, 32'h0001_2345);
    tick();
    word("mr_ori", 32'h3421_2345, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", {31'b0, out_valid}, 32'd0);
    chk("mr_instr", out_instr, 32'h0);
    chk("mr_last", {31'b0, out_last}, 32'd0);
    chk("mr_inrdy", {31'b0, in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    idle("mr_post");
    send(6'b001101, 5'd0, 5'd6, 32'h0000_8000);
    word("mr_new", 32'h3406_8000, 1'b1);
    tick();
    idle("mr_done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
